// File: rtl/mem_access_ctrl_if.sv
// Request/response channel bundle for mem_access_ctrl.
// The slave modport is the controller side; the master modport is the requester side.
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Request-driven initiator for the 16x8 RAM with a 4-entry read-response buffer.
// Define MEM_ACCESS_CTRL_BURST_EN to honour req_len (read bursts of req_len+1 beats).
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_ctrl_if.slave      bus,
    output logic                  mem_wr_enb,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_enb,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);
`ifdef MEM_ACCESS_CTRL_BURST_EN
    localparam int BEAT_W = LEN_WIDTH + 1;
`else
    localparam int BEAT_W = 1;
`endif
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1'b1);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BEAT_W-1:0]     r_beats;
    logic [BEAT_W-1:0]     w_beats_cur;
    logic [BEAT_W-1:0]     w_beats_nxt;
    logic [BEAT_W-1:0]     w_beats_init;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_cur;
    logic [2:0]            r_outst;
    logic [2:0]            w_outst_nxt;
    logic                  w_accept;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_issue;
    logic                  w_pop;
    logic                  r_mem_wr_enb;
    logic [ADDR_WIDTH-1:0] r_mem_wr_addr;
    logic [DATA_WIDTH-1:0] r_mem_wr_data;
    logic                  r_mem_rd_enb;
    logic [ADDR_WIDTH-1:0] r_mem_rd_addr;
    logic                  r_rd_last;
    logic                  r_push_vld;
    logic                  r_push_last;
    logic [DATA_WIDTH-1:0] r_buf_data [4];
    logic [3:0]            r_buf_last;
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;
    logic                  r_req_ready;
    logic                  r_busy;

`ifdef MEM_ACCESS_CTRL_BURST_EN
    assign w_beats_init = {1'b0, bus.req_len} + BEAT_ONE;
`else
    logic w_unused_len;
    assign w_beats_init = 1'b1;
    assign w_unused_len = ^bus.req_len;
`endif

    // Request acceptance, next state and read-beat scheduling against buffer credit
    always_comb begin
        w_accept    = bus.req_valid & (r_state == IDLE);
        w_wr_fire   = w_accept & bus.req_wr;
        w_rd_fire   = w_accept & ~bus.req_wr;
        w_state_nxt = r_state;
        w_beats_cur = r_beats;
        w_addr_cur  = r_addr;
        case (r_state)
            IDLE: begin
                if (w_wr_fire) begin
                    w_state_nxt = WRITE;
                end else if (w_rd_fire) begin
                    w_state_nxt = READ;
                    w_beats_cur = w_beats_init;
                    w_addr_cur  = bus.req_addr;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WRITE:   w_state_nxt = IDLE;
            READ: begin
                if (r_beats == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = READ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Outstanding counts scheduled, in-flight and buffered beats, so 4 caps the buffer
        w_issue = (w_rd_fire | (r_state == READ)) & (w_beats_cur != '0) & (r_outst != 3'd4);
        if (w_issue) begin
            w_beats_nxt = w_beats_cur - BEAT_ONE;
        end else begin
            w_beats_nxt = w_beats_cur;
        end
        w_pop       = (r_count != 3'd0) & bus.rsp_ready;
        w_outst_nxt = r_outst + {2'b00, w_issue} - {2'b00, w_pop};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered RAM ports, beat/address tracking, credit and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats       <= '0;
            r_addr        <= '0;
            r_outst       <= 3'd0;
            r_mem_wr_enb  <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_mem_rd_enb  <= 1'b0;
            r_mem_rd_addr <= '0;
            r_rd_last     <= 1'b0;
            r_push_vld    <= 1'b0;
            r_push_last   <= 1'b0;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_beats      <= w_beats_nxt;
            r_addr       <= w_issue ? (w_addr_cur + ADDR_WIDTH'(1'b1)) : w_addr_cur;
            r_outst      <= w_outst_nxt;
            r_mem_wr_enb <= w_wr_fire;
            if (w_wr_fire) begin
                r_mem_wr_addr <= bus.req_addr;
                r_mem_wr_data <= bus.req_wdata;
            end
            r_mem_rd_enb <= w_issue;
            if (w_issue) begin
                r_mem_rd_addr <= w_addr_cur;
                r_rd_last     <= (w_beats_nxt == '0);
            end
            r_push_vld  <= r_mem_rd_enb;
            r_push_last <= r_rd_last;
            r_req_ready <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE) | (w_outst_nxt != 3'd0);
        end
    end

    // Response FIFO of {data, last}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_buf_data[i] <= '0;
            end
            r_buf_last <= 4'd0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
        end else begin
            if (r_push_vld) begin
                r_buf_data[r_wr_ptr] <= mem_rd_data;
                r_buf_last[r_wr_ptr] <= r_push_last;
                r_wr_ptr             <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, r_push_vld} - {2'b00, w_pop};
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = (r_count != 3'd0);
    assign bus.rsp_data  = r_buf_data[r_rd_ptr];
    assign bus.rsp_last  = r_buf_last[r_rd_ptr];
    assign mem_wr_enb    = r_mem_wr_enb;
    assign mem_wr_addr   = r_mem_wr_addr;
    assign mem_wr_data   = r_mem_wr_data;
    assign mem_rd_enb    = r_mem_rd_enb;
    assign mem_rd_addr   = r_mem_rd_addr;
    assign busy          = r_busy;
endmodule
